// File: rtl/wb_uart_tx_fifo.sv
// Wishbone-attached UART transmitter: CPU byte writes are queued in a FIFO and
// sent 8N1, LSB first, on o_tx. STATUS exposes FIFO level, busy and a sticky overflow flag.
module wb_uart_tx_fifo #(
  parameter int DIVISOR = 434,
  parameter int DEPTH   = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic        o_tx
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0]   BAUD_RELOAD = 16'(DIVISOR - 1);
  localparam logic [CW-1:0] FULL_COUNT  = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_ack;
  logic [31:0]   r_dat;
  tx_state_t     r_state;
  logic [15:0]   r_baud;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic          w_req;
  logic          w_push;
  logic          w_stat_rd;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_ovf_set;
  logic [31:0]   w_status;
  logic          w_unused;

  // Bus request decode and FIFO push/pop qualification
  always_comb begin
    w_req     = i_wb_cyc & i_wb_stb & ~r_ack;
    w_full    = (r_count == FULL_COUNT);
    w_empty   = (r_count == CW'(0));
    w_push    = w_req & i_wb_we & ~i_wb_adr[2];
    w_stat_rd = w_req & ~i_wb_we & i_wb_adr[2];
    w_pop     = (r_state == ST_IDLE) & ~w_empty;
    // A pop on the same edge frees the slot, so a push to a full FIFO still lands.
    w_push_ok = w_push & (~w_full | w_pop);
    w_ovf_set = w_push & w_full & ~w_pop;
    w_status  = {19'd0, 9'(r_count), r_ovf, (r_state != ST_IDLE), w_empty, w_full};
  end

  assign w_unused = ^{i_wb_adr[31:3], i_wb_adr[1:0], i_wb_dat[31:8]};

  // Single-cycle ack, read data and sticky overflow flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
      r_ovf <= 1'b0;
    end else begin
      r_ack <= w_req;
      r_dat <= w_stat_rd ? w_status : 32'd0;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_stat_rd) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= AW'(0);
      r_rptr  <= AW'(0);
      r_count <= CW'(0);
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are discarded on reset by clearing the pointers
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wb_dat[7:0];
  end

  // Transmit FSM with baud counter and registered serial output
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_baud  <= 16'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_shift <= r_mem[r_rptr];
            r_baud  <= BAUD_RELOAD;
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end else begin
            r_tx <= 1'b1;
          end
        end
        ST_START: begin
          if (r_baud == 16'd0) begin
            r_baud  <= BAUD_RELOAD;
            r_bit   <= 3'd0;
            r_tx    <= r_shift[0];
            r_state <= ST_DATA;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        ST_DATA: begin
          if (r_baud == 16'd0) begin
            r_baud <= BAUD_RELOAD;
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        ST_STOP: begin
          if (r_baud == 16'd0) begin
            r_tx    <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx     = r_tx;
  assign o_wb_ack = r_ack;
  assign o_wb_dat = r_dat;

endmodule

// File: tb/tb_wb_uart_tx_fifo.sv
// Bench for wb_uart_tx_fifo: directed steps plus a random phase, checked against a
// queue-based model of the FIFO and frame timing and a serial-line decoder.
module tb_wb_uart_tx_fifo;

  localparam int D  = 4;
  localparam int DP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wcyc;
  logic        wstb;
  logic        wwe;
  logic [31:0] wadr;
  logic [31:0] wdat;
  logic [31:0] odat;
  logic        oack;
  logic        otx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  // model state: queued bytes, bytes expected on the line, overflow, first idle cycle
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  logic [8:0] rx_q[$];
  int         rx_st[$];
  logic       m_ovf = 1'b0;
  logic       m_ack = 1'b0;
  int         m_idle_from = 0;
  logic       tx_hist [0:32767];

  wb_uart_tx_fifo #(.DIVISOR(D), .DEPTH(DP)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_wb_cyc (wcyc),
    .i_wb_stb (wstb),
    .i_wb_we  (wwe),
    .i_wb_adr (wadr),
    .i_wb_dat (wdat),
    .o_wb_dat (odat),
    .o_wb_ack (oack),
    .o_tx     (otx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc_n);
    $fatal(1);
  end

  // Reference model: a frame occupies 10*D cycles after its pop, then one idle cycle.
  always @(posedge clk) begin
    logic req;
    if (rst) begin
      if (cyc_n < m_idle_from && exp_q.size() > 0) void'(exp_q.pop_back());
      m_q.delete();
      m_ovf = 1'b0;
      m_ack = 1'b0;
      m_idle_from = cyc_n + 1;
    end else begin
      req = wcyc & wstb & ~m_ack;
      if (cyc_n >= m_idle_from && m_q.size() > 0) begin
        exp_q.push_back(m_q.pop_front());
        m_idle_from = cyc_n + 10 * D + 1;
      end
      if (req && wwe && !wadr[2]) begin
        if (m_q.size() < DP) m_q.push_back(wdat[7:0]);
        else m_ovf = 1'b1;
      end else if (req && !wwe && wadr[2]) begin
        m_ovf = 1'b0;
      end
      m_ack = req;
    end
    cyc_n++;
  end

  always @(negedge clk) begin
    if (cyc_n < 32768) tx_hist[cyc_n] <= otx;
  end

  // Serial decoder: samples mid-bit, drops any frame that saw a reset.
  initial begin
    logic       p;
    logic [7:0] b;
    logic       ab;
    logic       stp;
    int         st;
    p = 1'b1;
    forever begin
      @(negedge clk);
      if (p === 1'b1 && otx === 1'b0) begin
        st = cyc_n;
        ab = rst;
        b  = 8'd0;
        repeat (D / 2) begin @(negedge clk); ab |= rst; end
        for (int i = 0; i < 8; i++) begin
          repeat (D) begin @(negedge clk); ab |= rst; end
          b[i] = otx;
        end
        repeat (D) begin @(negedge clk); ab |= rst; end
        stp = otx;
        if (!ab) begin
          rx_q.push_back({stp, b});
          rx_st.push_back(st);
        end
      end
      p = otx;
    end
  end

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'd0;
    s[12:4] = 9'(m_q.size());
    s[3]    = m_ovf;
    s[2]    = (cyc_n < m_idle_from);
    s[1]    = (m_q.size() == 0);
    s[0]    = (m_q.size() == DP);
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One Wishbone transaction starting in the current cycle; returns two cycles later.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     output logic [31:0] rd);
    logic [31:0] exp;
    exp  = (!we && adr[2]) ? m_status() : 32'd0;
    wcyc = 1'b1; wstb = 1'b1; wwe = we; wadr = adr; wdat = dat;
    @(posedge clk); #1;
    chk("ack", 64'(oack), 64'(1'b1));
    rd = odat;
    if (!we) chk("rd_data", 64'(odat), 64'(exp));
    wcyc = 1'b0; wstb = 1'b0; wwe = 1'b0;
    @(posedge clk); #1;
    chk("ack_pulse", 64'(oack), 64'(1'b0));
    chk("dat_idle", 64'(odat), 64'(0));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((m_q.size() != 0 || cyc_n < m_idle_from + D) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_in_time", 64'(n < budget), 64'(1'b1));
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_nframes"}, 64'(rx_q.size()), 64'(exp_q.size()));
    while (rx_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_frame"}, 64'(rx_q.pop_front()), 64'({1'b1, exp_q.pop_front()}));
    rx_q.delete();
    exp_q.delete();
    rx_st.delete();
  endtask

  initial begin
    logic [31:0] rd;
    logic [41:0] obs_v;
    logic [41:0] exp_v;
    logic [7:0]  b;
    logic [3:0]  av;
    logic        quiet;
    int          c0;
    int          t;
    int          f;

    rst = 1'b1; wcyc = 1'b0; wstb = 1'b0; wwe = 1'b0; wadr = 32'd0; wdat = 32'd0;
    repeat (3) @(posedge clk); #1;
    chk("rst_tx", 64'(otx), 64'(1'b1));
    chk("rst_ack", 64'(oack), 64'(1'b0));
    chk("rst_dat", 64'(odat), 64'(0));
    rst = 1'b0;
    bus(1'b0, 32'h4, 32'd0, rd);
    chk("rst_status", 64'(rd), 64'(32'h002));

    // single byte 0x55: exact line waveform, one idle cycle either side
    c0 = cyc_n;
    b  = 8'h55;
    bus(1'b1, 32'h0, 32'h55, rd);
    wait_drain(2000);
    for (int k = 0; k < 42; k++) begin
      obs_v[k] = tx_hist[c0 + 1 + k];
      if (k == 0 || k == 41) exp_v[k] = 1'b1;
      else begin
        f = (k - 1) / D;
        exp_v[k] = (f == 0) ? 1'b0 : (f == 9) ? 1'b1 : b[f - 1];
      end
    end
    chk("t1_wave", 64'(obs_v), 64'(exp_v));
    bus(1'b0, 32'h4, 32'd0, rd);
    chk("t1_status", 64'(rd), 64'(32'h002));
    check_frames("t1");

    // burst of three: back-to-back frames 10*D+1 apart
    bus(1'b1, 32'h0, 32'h41, rd);
    bus(1'b1, 32'h0, 32'h42, rd);
    bus(1'b1, 32'h0, 32'h43, rd);
    bus(1'b0, 32'h4, 32'd0, rd);
    chk("t2_count", 64'(rd[12:4]), 64'(2));
    wait_drain(3000);
    chk("t2_nstarts", 64'(rx_st.size()), 64'(3));
    for (int i = 1; i < rx_st.size(); i++)
      chk("t2_spacing", 64'(rx_st[i] - rx_st[i - 1]), 64'(10 * D + 1));
    check_frames("t2");

    // overflow while busy: 1 in flight, 4 queued, 1 dropped
    for (int i = 0; i < 6; i++) bus(1'b1, 32'h0, $urandom, rd);
    bus(1'b0, 32'h4, 32'd0, rd);
    chk("t3_status", 64'(rd), 64'(32'h04D));
    bus(1'b0, 32'h4, 32'd0, rd);
    chk("t3_status2", 64'(rd), 64'(32'h045));
    wait_drain(5000);
    check_frames("t3");

    // push into a full FIFO on the very edge the idle FSM pops
    for (int i = 0; i < 5; i++) bus(1'b1, 32'h0, $urandom, rd);
    t = m_idle_from;
    while (cyc_n < t) begin @(posedge clk); #1; end
    bus(1'b1, 32'h0, $urandom, rd);
    bus(1'b0, 32'h4, 32'd0, rd);
    chk("t4_status", 64'(rd), 64'(32'h045));
    wait_drain(6000);
    check_frames("t4");

    // reset during data bit 3 aborts the frame and discards the queued byte
    c0 = cyc_n;
    b  = 8'($urandom) & 8'hF7;
    bus(1'b1, 32'h0, {24'd0, b}, rd);
    bus(1'b1, 32'h0, $urandom, rd);
    while (cyc_n < c0 + 19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    chk("t5_bit3", 64'(tx_hist[c0 + 19]), 64'(1'b0));
    chk("t5_tx_high", 64'(tx_hist[c0 + 20]), 64'(1'b1));
    quiet = 1'b1;
    for (int k = c0 + 20; k < c0 + 130; k++) quiet &= tx_hist[k];
    chk("t5_quiet", 64'(quiet), 64'(1'b1));
    bus(1'b0, 32'h4, 32'd0, rd);
    chk("t5_status", 64'(rd), 64'(32'h002));
    check_frames("t5");

    // stb held four cycles: ack on alternate cycles, two bytes queued
    wcyc = 1'b1; wstb = 1'b1; wwe = 1'b1; wadr = 32'h0; wdat = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      av[i] = oack;
    end
    wcyc = 1'b0; wstb = 1'b0; wwe = 1'b0;
    chk("t6_ack_seq", 64'(av), 64'(4'b0101));
    bus(1'b0, 32'h0, 32'd0, rd);
    chk("t6_data_rd", 64'(rd), 64'(0));
    wait_drain(3000);
    check_frames("t6");

    // random mix of writes, status reads and idle gaps
    for (int i = 0; i < 40; i++) begin
      t = $urandom_range(0, 9);
      if (t < 5) bus(1'b1, $urandom & ~32'h4, $urandom, rd);
      else if (t < 8) bus(1'b0, $urandom | 32'h4, 32'd0, rd);
      else begin
        repeat ($urandom_range(1, 60)) @(posedge clk);
        #1;
      end
    end
    wait_drain(20000);
    bus(1'b0, 32'h4, 32'd0, rd);
    check_frames("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_uart_tx_fifo.md
# wb_uart_tx_fifo

Buffered UART transmitter on the Wishbone data bus, downstream of the crossbar's console port. Accepts byte writes from the CPU into a FIFO and serializes them 8N1, LSB first, on the `uart_tx` pin, so the CPU need not stall per character. A status register exposes FIFO level, busy, and a sticky overflow flag for polling software.

## Interface
- `DIVISOR`, 434: clock cycles per bit (50 MHz / 115200); legal range 2..65535.
- `DEPTH`, 16: FIFO depth in bytes; a power of two, 2..256.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `wb` WB4 slave modport: signals used are `cyc`, `stb`, `we`, `adr[31:0]`, `dat_i[31:0]`, `dat_o[31:0]`, `ack`. Only `adr[2]` is decoded.
- `tx` out 1: serial output, idle high.

## Operation
- Register map, byte offsets:
  - 0x0 DATA: a write enqueues `dat_i[7:0]`; a read returns 0.
  - 0x4 STATUS, read: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky), bits[12:4] FIFO count (0..DEPTH), all other bits 0. Writes are acked and ignored.
- Wishbone classic: `ack` is registered and asserted in the cycle after `cyc & stb` is seen. It is a single-cycle pulse, deasserted in the following cycle even if `stb` stays high. A new request is therefore accepted every 2 cycles at most.
- The request's side effect (enqueue, or overflow clear) commits on the same edge that raises `ack`. `dat_o` is valid while `ack`=1 and is 0 otherwise.
- Push to a full FIFO: the byte is dropped, overflow is set, and the write is still acked.
- Simultaneous push and pop while full: the push is accepted and count is unchanged.
- A STATUS read returns the pre-clear overflow value, then clears overflow. If an overflow occurs on that same edge, overflow stays set.
- FIFO storage uses circular read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH. Count uses log2(DEPTH)+1 bits.
- TX FSM states are IDLE, START, DATA, STOP:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register, load the baud counter with DIVISOR-1, and go to START.
  - START: `tx`=0 for DIVISOR cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0] for DIVISOR cycles per bit, shifting right. After bit 7, go to STOP.
  - STOP: `tx`=1 for DIVISOR cycles, then go to IDLE.
- The baud counter counts down from DIVISOR-1. A state or bit advances when the counter reaches 0, and the counter reloads at that point.
- Reset values: `tx`=1, `ack`=0, `dat_o`=0, state IDLE, pointers and count 0, overflow 0, shift register 0. Reset mid-frame aborts the frame immediately: `tx` is high from the next cycle and FIFO contents are discarded.

## Timing
- A write with `stb` at cycle 0 gives `ack` and count+1 in cycle 1.
- If the FSM is idle, the pop occurs at the end of cycle 1 and `tx` falls in cycle 2.
- Frame length: `tx` is low for DIVISOR cycles (start bit), then 8 data bits of DIVISOR cycles each, then high for DIVISOR cycles (stop bit). Total 10·DIVISOR cycles.
- Back-to-back frames have exactly one IDLE cycle between the end of a stop bit and the next start bit, giving a period of 10·DIVISOR+1 cycles.
- `busy` is 1 from the cycle after the pop through the last stop-bit cycle.
- Read latency is 1 cycle. STATUS reflects register state as of the cycle `stb` was sampled.

## Test plan
- Reset and single byte, DIVISOR=4: write 0x55 to 0x0 → `ack` in the next cycle, `tx` low 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then high 4 cycles. Total 40 cycles; STATUS afterwards reads 0x002 (empty, idle).
- Burst of 3 bytes 0x41, 0x42, 0x43 → three frames in order, start-bit falling edges 41 cycles apart. STATUS count reads 2 just after the first pop.
- Overflow, DEPTH=4, FSM busy: write 6 bytes → STATUS shows full=1, count=4, overflow=1. A second STATUS read shows overflow=0. Exactly 5 frames are sent (1 in flight plus 4 queued).
- Push while full with a simultaneous pop: time a write to the cycle where IDLE pops a full FIFO → byte accepted, count stays 4, overflow stays 0.
- Reset mid-frame during DATA bit 3: assert `rst` one cycle → `tx`=1 next cycle, STATUS=0x002, no further frames without new writes.
- Protocol: hold `stb` high for 4 cycles with `we`=1 → `ack` pulses in cycles 1 and 3 only, 2 bytes enqueued. A read of 0x0 returns 0.
